debug_frame_sender: RTL and testbench

Sequencer that owns the debug UART transmitter and streams one snapshot frame per request: header byte, N payload bytes (LSB byte first), then an XOR checksum. It sits between the debug command decoder and uart_tx. It latches a wide snapshot (register file, pipeline latch or memory word) on start and hands bytes to uart_tx one at a time using the tx_start/tx_done handshake. A watchdog aborts the frame if the transmitter stalls.

---
 rtl/debug_pkg.sv | 34 +++
 rtl/debug_frame_sender.sv | 113 +++++++++++
 tb/tb_debug_frame_sender.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared debug-port definitions: host command codes, frame sender state/phase
// encodings and pipeline-latch snapshot sizes.
package debug_pkg;

  localparam int BYTE_W = 8;

  localparam logic [7:0] CMD_SEND_REGS   = 8'h01;
  localparam logic [7:0] CMD_SEND_IF_ID  = 8'h02;
  localparam logic [7:0] CMD_SEND_ID_EX  = 8'h03;
  localparam logic [7:0] CMD_SEND_EX_MEM = 8'h04;
  localparam logic [7:0] CMD_SEND_MEM_WB = 8'h05;
  localparam logic [7:0] CMD_SEND_PC     = 8'h06;
  localparam logic [7:0] CMD_HALT        = 8'h07;
  localparam logic [7:0] CMD_RESUME      = 8'h08;
  localparam logic [7:0] CMD_RESET_CPU   = 8'h09;
  localparam logic [7:0] CMD_SET_BP      = 8'h0A;
  localparam logic [7:0] CMD_CLR_BP      = 8'h0B;
  localparam logic [7:0] CMD_STEP        = 8'h0C;
  localparam logic [7:0] CMD_READ_MEM    = 8'h0D;

  localparam int IF_ID_SIZE  = 32;
  localparam int ID_EX_SIZE  = 129;
  localparam int EX_MEM_SIZE = 77;
  localparam int MEM_WB_SIZE = 71;

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_DONE, S_ERR} sender_state_e;
  typedef enum logic [1:0] {PH_HDR, PH_PAY, PH_CSUM} sender_phase_e;

  // Payload length in bytes for a latch of the given bit width.
  function automatic int unsigned byte_count(input int unsigned bits);
    return (bits + BYTE_W - 1) / BYTE_W;
  endfunction

endpackage

// File: rtl/debug_frame_sender.sv
// Streams one snapshot frame (tag, payload LSB byte first, XOR checksum)
// through uart_tx via the tx_start/tx_done handshake, with a stall watchdog.
module debug_frame_sender
  import debug_pkg::*;
#(
  parameter int MAX_BYTES      = 128,
  parameter int FRAME_W        = MAX_BYTES * BYTE_W,
  parameter int CNT_W          = $clog2(MAX_BYTES + 1),
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [7:0]         i_tag,
  input  logic [CNT_W-1:0]   i_nbytes,
  input  logic [FRAME_W-1:0] i_frame,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic               o_tx_start,
  output logic [7:0]         o_tx_data,
  input  logic               i_tx_done
);

  localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  sender_state_e state_q, state_d;
  sender_phase_e phase_q;

  logic [MAX_BYTES-1:0][BYTE_W-1:0] frame_q;
  logic [BYTE_W-1:0] tag_q, csum_q, cur_byte;
  logic [CNT_W-1:0]  len_q, idx_q, idx_nxt, len_d;
  logic [TO_W-1:0]   wd_q;
  logic              wd_expired, advance;

  assign cur_byte   = frame_q[idx_q[IDX_W-1:0]];
  assign idx_nxt    = idx_q + CNT_W'(1);
  assign len_d      = (i_nbytes > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : i_nbytes;
  assign advance    = (state_q == S_WAIT) && i_tx_done;
  assign wd_expired = (wd_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (i_start) state_d = S_SEND;
      S_SEND: state_d = S_WAIT;
      // tx_done is checked first so a byte finishing on the terminal count still counts
      S_WAIT: begin
        if (i_tx_done)       state_d = (phase_q == PH_CSUM) ? S_DONE : S_SEND;
        else if (wd_expired) state_d = S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      frame_q <= '0;
      tag_q   <= '0;
      csum_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      wd_q    <= '0;
      phase_q <= PH_HDR;
    end else if (state_q == S_IDLE) begin
      if (i_start) begin
        frame_q <= i_frame;
        tag_q   <= i_tag;
        csum_q  <= i_tag;
        len_q   <= len_d;
        idx_q   <= '0;
        phase_q <= PH_HDR;
      end
    end else if (state_q == S_SEND) begin
      wd_q <= '0;
    end else if (advance) begin
      unique case (phase_q)
        PH_HDR: phase_q <= (len_q == '0) ? PH_CSUM : PH_PAY;
        PH_PAY: begin
          csum_q <= csum_q ^ cur_byte;
          idx_q  <= idx_nxt;
          if (idx_nxt == len_q) phase_q <= PH_CSUM;
        end
        default: ;
      endcase
    end else if (state_q == S_WAIT) begin
      wd_q <= wd_q + TO_W'(1);
    end
  end

  always_comb begin
    o_busy     = (state_q == S_SEND) || (state_q == S_WAIT);
    o_done     = (state_q == S_DONE);
    o_err      = (state_q == S_ERR);
    o_tx_start = (state_q == S_SEND);
    // Driven from registers only, so the byte stays put for the whole handshake
    unique case (phase_q)
      PH_HDR:  o_tx_data = tag_q;
      PH_PAY:  o_tx_data = cur_byte;
      PH_CSUM: o_tx_data = csum_q;
      default: o_tx_data = '0;
    endcase
  end

endmodule

// File: tb/tb_debug_frame_sender.sv
// Bench for debug_frame_sender: table of frame requests with a byte scoreboard,
// plus hand sequences for restart-ignore, watchdog abort and mid-frame reset.
module tb_debug_frame_sender;

  localparam int MAXB     = 128;
  localparam int TMO      = 20;
  localparam int RESP_DLY = 10;

  typedef logic [MAXB-1:0][7:0] frame_t;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_start;
  logic [7:0]        i_tag;
  logic [7:0]        i_nbytes;
  logic [MAXB*8-1:0] i_frame;
  logic              o_busy, o_done, o_err, o_tx_start;
  logic [7:0]        o_tx_data;
  logic              i_tx_done;

  debug_frame_sender #(.MAX_BYTES(MAXB), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_tag(i_tag),
    .i_nbytes(i_nbytes), .i_frame(i_frame), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .i_tx_done(i_tx_done)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0;
  int n_done = 0, n_err = 0;
  bit resp_en = 1'b1;
  logic [7:0] exp_q[$];
  logic [7:0] sent[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic frame_t gen_frame(input int seed);
    frame_t f;
    f = '0;
    if (seed == 0) begin
      f[3] = 8'hDE; f[2] = 8'hAD; f[1] = 8'hBE; f[0] = 8'hEF;
    end else begin
      for (int k = 0; k < MAXB; k++) f[7'(k)] = 8'(k * seed + 17 * seed + 1);
    end
    return f;
  endfunction

  function automatic logic [7:0] ref_csum(input logic [7:0] tag, input int nb, input frame_t f);
    logic [7:0] c;
    int n;
    n = (nb > MAXB) ? MAXB : nb;
    c = tag;
    for (int k = 0; k < n; k++) c = c ^ f[7'(k)];
    return c;
  endfunction

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  initial forever begin
    @(negedge i_clk);
    if (o_done) n_done++;
    if (o_err)  n_err++;
  end

  // uart_tx stand-in: scoreboard each started byte, answer with tx_done later
  initial begin
    logic [7:0] b;
    bit abort, just;
    i_tx_done = 1'b0;
    just = 1'b0;
    forever begin
      if (!just) @(negedge i_clk);
      just = 1'b0;
      if (o_tx_start && !i_reset) begin
        b = o_tx_data;
        sent.push_back(b);
        start_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_byte: got %0h expected none", b);
        end else chk("tx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
        if (resp_en) begin
          abort = 1'b0;
          repeat (RESP_DLY - 1) begin
            @(negedge i_clk);
            if (i_reset) abort = 1'b1;
          end
          if (!abort) begin
            chk("tx_data_stable", {24'd0, o_tx_data}, {24'd0, b});
            i_tx_done = 1'b1;
            @(negedge i_clk);
            i_tx_done = 1'b0;
            just = 1'b1;
          end
        end
      end
    end
  end

  task automatic issue_start(input logic [7:0] tag, input logic [7:0] nb, input frame_t fr);
    int len;
    logic [7:0] cs;
    len = (nb > MAXB) ? MAXB : int'(nb);
    sent.delete();
    cs = tag;
    exp_q.push_back(tag);
    for (int k = 0; k < len; k++) begin
      exp_q.push_back(fr[7'(k)]);
      cs = cs ^ fr[7'(k)];
    end
    exp_q.push_back(cs);
    @(negedge i_clk);
    i_tag = tag; i_nbytes = nb; i_frame = fr; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_end(output bit got_done, output bit got_err, output int end_cyc);
    bit busy_bad;
    got_done = 0; got_err = 0; busy_bad = 0; end_cyc = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge i_clk);
      if (o_done || o_err) begin
        got_done = o_done; got_err = o_err; end_cyc = cyc;
        chk("busy_low_at_end", {31'd0, o_busy}, 32'd0);
        break;
      end
      if (!o_busy) busy_bad = 1'b1;
    end
    if (!got_done && !got_err) begin
      n_tests++; n_fail++;
      $display("FAIL frame_timeout: got no done/err expected end within 4000 cycles");
    end
    chk("busy_during_frame", {31'd0, busy_bad}, 32'd0);
    @(negedge i_clk);
    chk("end_pulse_1cyc", {30'd0, o_done, o_err}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] tag;
    logic [7:0] nbytes;
    int         seed;
    int         exp_total;
    logic [7:0] exp_csum;
  } vec_t;

  vec_t vecs[6];

  initial begin
    frame_t fr;
    logic [MAXB*8-1:0] flat;
    bit gd, ge;
    int ec, d0, e0;

    i_reset = 1'b1; i_start = 1'b0; i_tag = '0; i_nbytes = '0; i_frame = '0;
    repeat (3) @(negedge i_clk);
    chk("rst_ctrl", {28'd0, o_busy, o_done, o_err, o_tx_start}, 32'd0);
    chk("rst_data", {24'd0, o_tx_data}, 32'd0);
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);

    vecs[0] = '{8'h02, 8'd4,   0, 6,   8'h20};
    vecs[1] = '{8'h0B, 8'd0,   3, 2,   8'h0B};
    vecs[2] = '{8'h01, 8'd200, 5, 130, 8'h00};
    vecs[3] = '{8'h0D, 8'd128, 7, 130, 8'h00};
    vecs[4] = '{8'h05, 8'd1,   3, 3,   8'h00};
    vecs[5] = '{8'h0C, 8'd129, 2, 130, 8'h00};
    for (int i = 2; i < 6; i++)
      vecs[i].exp_csum = ref_csum(vecs[i].tag, int'(vecs[i].nbytes), gen_frame(vecs[i].seed));

    for (int i = 0; i < 6; i++) begin
      fr = gen_frame(vecs[i].seed);
      flat = fr;
      d0 = n_done; e0 = n_err;
      issue_start(vecs[i].tag, vecs[i].nbytes, fr);
      wait_end(gd, ge, ec);
      chk("vec_done", {31'd0, gd}, 32'd1);
      chk("vec_done_cnt", n_done - d0, 32'd1);
      chk("vec_err_cnt", n_err - e0, 32'd0);
      chk("vec_total", sent.size(), vecs[i].exp_total);
      chk("vec_pending", exp_q.size(), 32'd0);
      if (sent.size() > 0)
        chk("vec_csum", {24'd0, sent[sent.size()-1]}, {24'd0, vecs[i].exp_csum});
      if (vecs[i].nbytes >= MAXB && sent.size() > 128)
        chk("vec_pay127", {24'd0, sent[128]}, {24'd0, flat[1023:1016]});
      exp_q.delete();
    end

    // Restart and frame change while busy must not disturb the frame in flight
    d0 = n_done;
    issue_start(8'h03, 8'd5, gen_frame(9));
    repeat (15) @(negedge i_clk);
    i_frame = gen_frame(11); i_nbytes = 8'd9; i_tag = 8'hFF; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_end(gd, ge, ec);
    chk("mid_total", sent.size(), 32'd7);
    chk("mid_pending", exp_q.size(), 32'd0);
    chk("mid_done_cnt", n_done - d0, 32'd1);
    exp_q.delete();

    // Watchdog: header never acknowledged
    resp_en = 1'b0;
    e0 = n_err; d0 = n_done;
    issue_start(8'h07, 8'd2, gen_frame(4));
    wait_end(gd, ge, ec);
    chk("wd_err", {31'd0, ge}, 32'd1);
    chk("wd_latency", ec - start_cyc, 32'd21);
    chk("wd_bytes", sent.size(), 32'd1);
    chk("wd_err_cnt", n_err - e0, 32'd1);
    chk("wd_done_cnt", n_done - d0, 32'd0);
    exp_q.delete();
    resp_en = 1'b1;
    issue_start(8'h06, 8'd3, gen_frame(6));
    wait_end(gd, ge, ec);
    chk("post_wd_done", {31'd0, gd}, 32'd1);
    chk("post_wd_total", sent.size(), 32'd5);
    exp_q.delete();

    // Reset while waiting on a payload byte
    issue_start(8'h04, 8'd6, gen_frame(8));
    for (int c = 0; c < 500 && sent.size() < 4; c++) @(negedge i_clk);
    chk("rst_reach_byte3", sent.size(), 32'd4);
    repeat (3) @(negedge i_clk);
    d0 = n_done; e0 = n_err;
    i_reset = 1'b1;
    #1;
    chk("midrst_ctrl", {28'd0, o_busy, o_done, o_err, o_tx_start}, 32'd0);
    chk("midrst_data", {24'd0, o_tx_data}, 32'd0);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    exp_q.delete();
    repeat (20) @(negedge i_clk);
    chk("midrst_no_done", n_done - d0, 32'd0);
    chk("midrst_no_err", n_err - e0, 32'd0);
    chk("midrst_idle", {31'd0, o_busy}, 32'd0);
    issue_start(8'h0A, 8'd2, gen_frame(13));
    wait_end(gd, ge, ec);
    chk("post_rst_done", {31'd0, gd}, 32'd1);
    chk("post_rst_total", sent.size(), 32'd4);
    chk("post_rst_pending", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
